serial_adder: RTL and testbench

- Bit-serial ripple adder. It is the addition counterpart of the team's 4-bit borrow-ripple subtractor (A - B - bin -> D, b[4:1]).
- Computes A + B + cin one bit per clock, LSB first, using a single full-adder cell and a carry flop.
- Exposes per-stage carries c[WIDTH:1] so results check directly against the subtractor's borrow vector convention.
- Used in the lab datapath wherever area matters more than latency; start/done handshake to the controlling FSM.

---
 rtl/serial_adder.sv | 150 +++++++++++++++
 tb/tb_serial_adder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: computes A + B + cin one bit per clock, LSB first,
// using a single full-adder cell and a carry flop. Per-stage carries are
// exposed as c[WIDTH:1] so results line up with the borrow-ripple
// subtractor's b[WIDTH:1] vector. A start/done handshake connects it to the
// controlling FSM.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic [WIDTH:1]   c,
   output logic             cout
);

   // Bit counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             cy;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH:1]   carry_q;

   logic             cell_sum;
   logic             cell_carry;
   logic [WIDTH-1:0] sum_next;
   logic [WIDTH:1]   carry_next;

   // State register; reset wins over any start on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others, regardless of block order.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: IDLE -> ADD on start, ADD -> DONE after the last bit,
   // DONE -> IDLE unconditionally (start during DONE is not queued).
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves the
      // variable unassigned, which would otherwise infer a latch.
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = ADD;
            end
         end
         ADD: begin
            if (cnt == LAST_BIT) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The single full-adder cell working on the current LSBs and the carry flop.
   always_comb begin
      cell_sum   = a_sr[0] ^ b_sr[0] ^ cy;
      cell_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & cy) | (b_sr[0] & cy);
   end

   // Place the cell outputs into bit cnt of the sum and stage cnt+1 of the
   // carry vector; all other bits keep their previous value.
   always_comb begin
      sum_next   = sum_q;
      carry_next = carry_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt == CW'(i)) begin
            sum_next[i]       = cell_sum;
            carry_next[i + 1] = cell_carry;
         end
      end
   end

   // Datapath: capture operands on an accepted start, then one bit per ADD
   // cycle. Results are left untouched in IDLE and DONE so they persist.
   always_ff @(posedge clk) begin
      // NOTE: every datapath register, including the operand shift registers
      // and the result vectors, is cleared by reset so an abort leaves no
      // stale partial result visible on S/c/cout.
      if (rst) begin
         a_sr    <= '0;
         b_sr    <= '0;
         cy      <= 1'b0;
         cnt     <= '0;
         sum_q   <= '0;
         carry_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sr    <= A;
                  b_sr    <= B;
                  cy      <= cin;
                  cnt     <= '0;
                  sum_q   <= '0;
                  carry_q <= '0;
               end
            end
            ADD: begin
               sum_q   <= sum_next;
               carry_q <= carry_next;
               cy      <= cell_carry;
               a_sr    <= a_sr >> 1;
               b_sr    <= b_sr >> 1;
               cnt     <= cnt + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Handshake flags decode straight from the registered state.
   assign busy = (state == ADD);
   assign done = (state == DONE);

   assign S    = sum_q;
   assign c    = carry_q;
   assign cout = carry_q[WIDTH];

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, a mid-operation
// reset, spurious starts while busy/done, a full 512-case sweep, random
// operands, and a subtract-then-add round trip, all against an arithmetic
// reference model.
module tb_serial_adder;

   localparam int W = 4;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] S;
   logic [W:1]   c;
   logic         cout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .c     (c),
      .cout  (cout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Full unsigned sum, WIDTH+1 bits meaningful.
   function automatic int ref_sum(int a, int b, int ci);
      return a + b + ci;
   endfunction

   // Carry out of stage i is the overflow of adding the low i bits plus cin;
   // bit i-1 of the result corresponds to c[i].
   function automatic int ref_carries(int a, int b, int ci);
      int r = 0;
      for (int i = 1; i <= W; i++) begin
         int m = (1 << i) - 1;
         if ((((a & m) + (b & m) + ci) >> i) != 0) r |= (1 << (i - 1));
      end
      return r;
   endfunction

   // One transaction starting from IDLE. Inputs are scrambled while busy to
   // show only the latched operands matter; with noise set, start is held
   // high with all-ones operands through ADD and DONE.
   task automatic run_op(input int a, input int b, input int ci, input bit noise, input string tag);
      int cycles;
      int busy_cnt;
      int total;
      @(negedge clk);
      check({tag, ":idle"}, {30'd0, busy, done}, 32'd0);
      A = W'(a);
      B = W'(b);
      cin = 1'(ci);
      start = 1'b1;
      @(negedge clk);
      cycles = 1;
      busy_cnt = 0;
      while (!done && cycles <= 3 * W) begin
         if (busy) busy_cnt++;
         if (noise) begin
            A = '1;
            B = '1;
            cin = 1'b1;
            start = 1'b1;
         end else begin
            A = W'($urandom);
            B = W'($urandom);
            cin = 1'($urandom);
            start = 1'($urandom);
         end
         @(negedge clk);
         cycles++;
      end
      start = noise;
      total = ref_sum(a, b, ci);
      check({tag, ":latency"}, cycles, W + 1);
      check({tag, ":busy_cycles"}, busy_cnt, W);
      check({tag, ":S"}, {28'd0, S}, total & MASK);
      check({tag, ":c"}, {28'd0, c}, ref_carries(a, b, ci));
      check({tag, ":cout"}, {31'd0, cout}, (total >> W) & 1);
      if (noise) begin
         @(negedge clk);
         check({tag, ":no_queue"}, {30'd0, busy, done}, 32'd0);
         start = 1'b0;
      end
   endtask

   initial begin
      int pulses;
      rst = 1'b1;
      start = 1'b1;
      A = '1;
      B = '1;
      cin = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_state", {21'd0, busy, done, S, c, cout}, 32'd0);
      start = 1'b0;
      rst = 1'b0;

      // Directed cases from the plan.
      run_op(0, 0, 0, 1'b0, "zero");
      run_op(15, 15, 1, 1'b0, "all_ones");
      run_op(7, 1, 0, 1'b0, "seven_plus_one");
      run_op(9, 6, 0, 1'b0, "nine_plus_six");
      run_op(3, 5, 0, 1'b1, "spurious_start");

      // Reset during the second ADD cycle aborts without a done pulse.
      @(negedge clk);
      A = 4'd3;
      B = 4'd0;
      cin = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_outputs", {21'd0, busy, done, S, c, cout}, 32'd0);
      pulses = 0;
      repeat (W + 2) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      check("abort_no_done", pulses, 0);
      run_op(10, 7, 1, 1'b0, "after_abort");

      // Exhaustive sweep, cin slowest, back-to-back starts.
      for (int n = 0; n < 512; n++) begin
         run_op(n & 15, (n >> 4) & 15, (n >> 8) & 1, 1'b0, $sformatf("sweep%0d", n));
      end

      // Random operands.
      for (int n = 0; n < 100; n++) begin
         run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
                int'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", n));
      end

      // Subtractor round trip: D = A - B - bin, then D + B + bin gives A back
      // and the carry-out equals the subtractor's final borrow.
      for (int n = 0; n < 40; n++) begin
         int a = int'($urandom_range(0, MASK));
         int b = int'($urandom_range(0, MASK));
         int bin = int'($urandom_range(0, 1));
         int d = (a - b - bin) & MASK;
         run_op(d, b, bin, 1'b0, $sformatf("trip%0d", n));
         check($sformatf("trip%0d:restores_a", n), {28'd0, S}, a);
         check($sformatf("trip%0d:borrow", n), {31'd0, cout}, (a < b + bin) ? 1 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
